taxi_fare_engine: RTL and testbench
===================================

// Module: taxi_fare_engine
// PURPOSE
//  Trip metering core: syncs raw encoder_pulses, counts distance, computes fare (base + per-distance + waiting).
//  Driven by debounced launch/step flags; replaces unsynchronised distance/price counting.
//  distance/price feed the binary2bcd_216 instances directly; all logic on sys_clk.
// PARAMETERS
//  PULSES_PER_UNIT  16'd100        encoder rising edges per distance unit
//  BASE_DIST        20'd3          distance units covered by base fare
//  BASE_FARE        20'd8          price loaded at trip start
//  RATE_PER_UNIT    20'd2          price added per distance unit beyond BASE_DIST
//  WAIT_CYCLES      32'd100_000_000 sys_clk cycles without encoder edge per wait charge (2 s @50 MHz)
//  WAIT_FARE        20'd1          price added per wait period
//  MAX_VAL          20'd999        saturation limit for distance and price (3-digit display)
// PORTS
//  sys_clk          in   1   system clock
//  sys_rst_n        in   1   asynchronous active-low reset
//  encoder_pulses   in   1   raw asynchronous encoder pulse train
//  flag_key_launch  in   1   1-cycle debounced launch pulse
//  flag_key_step    in   1   1-cycle debounced step pulse
//  distance         out  20  current trip distance, binary
//  price            out  20  current trip fare, binary
//  trip_state       out  2   00 IDLE, 01 RUN, 10 PAUSE (11 unused)
//  update           out  1   1-cycle pulse in the cycle distance or price changes
// BEHAVIOUR
//  Reset (async): distance=0, price=0, trip_state=IDLE, update=0, sync flops/sub-counter/wait timer=0.
//  Input: encoder_pulses -> 2-FF sync -> edge reg; rising edge detected in sync domain.
//  Latency: distance/price/update change on 3rd rising sys_clk edge after encoder_pulses rises.
//  FSM (flags sampled only when exactly one is high; both high same cycle -> ignored):
//   IDLE  + launch -> RUN; distance=0, price=BASE_FARE, sub-counter=0, timer=0, update=1.
//   RUN   + step   -> PAUSE; values frozen.
//   PAUSE + launch -> RUN; values kept (resume), timer=0.
//   PAUSE + step   -> IDLE; values held for display until next launch.
//   IDLE + step, RUN + launch: no effect.
//  RUN counting:
//   - each detected edge: sub-counter++; at PULSES_PER_UNIT-1 wraps to 0, distance+1.
//   - distance step to new value d: if d > BASE_DIST, price += RATE_PER_UNIT.
//   - edges in IDLE/PAUSE ignored; sub-counter holds.
//  Waiting charge (RUN only): timer counts cycles since last edge; at WAIT_CYCLES-1 -> price += WAIT_FARE,
//   timer=0. Detected edge clears timer same cycle (edge has priority; no wait charge that cycle).
//   Timer held at 0 in IDLE/PAUSE.
//  Saturation: distance, price clamp at MAX_VAL; no wrap. update only if value actually changes.
//  Width: internal sums 21-bit before clamp; sub-counter 16-bit, timer 32-bit.
//  Reset mid-trip: immediate return to reset values; no charge issued.
// TESTING (PULSES_PER_UNIT=4, BASE_DIST=3, BASE_FARE=8, RATE_PER_UNIT=2, WAIT_CYCLES=20, WAIT_FARE=1)
//  1 reset, launch pulse -> trip_state=01, distance=0, price=8, one update pulse.
//  2 RUN, 20 encoder pulses spaced <20 cycles -> distance=5, price=12; update on 3rd clk after 4th,8th.. rise.
//  3 RUN, no pulses for 45 cycles -> price +2 (at cycles 20, 40); distance unchanged.
//  4 step -> PAUSE, 8 pulses -> no change; launch -> RUN values kept; step,step -> IDLE, values held;
//    launch -> distance=0, price=8.
//  5 MAX_VAL=15, 40 pulses -> price stops at 15, distance reaches 10; no update once price saturated
//    except on distance steps.
//  6 launch+step same cycle in IDLE -> stays IDLE; sys_rst_n low mid-RUN -> all outputs 0, IDLE, async.

Source files
------------

// File: rtl/taxi_fare_if.sv
// Trip meter bundle: raw encoder and key flags in,
// binary distance/price/state and change strobe out.
interface taxi_fare_if;
  logic        encoder_pulses;
  logic        flag_key_launch;
  logic        flag_key_step;
  logic [19:0] distance;
  logic [19:0] price;
  logic [1:0]  trip_state;
  logic        update;

  modport master (
    output encoder_pulses,
    output flag_key_launch,
    output flag_key_step,
    input  distance,
    input  price,
    input  trip_state,
    input  update
  );

  modport slave (
    input  encoder_pulses,
    input  flag_key_launch,
    input  flag_key_step,
    output distance,
    output price,
    output trip_state,
    output update
  );
endinterface

// File: rtl/taxi_fare_engine.sv
// Taxi trip meter: synchronised encoder edges drive distance,
// fare adds base, per-unit and waiting charges, all saturating.
module taxi_fare_engine #(
  parameter logic [15:0] PULSES_PER_UNIT = 16'd100,
  parameter logic [19:0] BASE_DIST       = 20'd3,
  parameter logic [19:0] BASE_FARE       = 20'd8,
  parameter logic [19:0] RATE_PER_UNIT   = 20'd2,
  parameter logic [31:0] WAIT_CYCLES     = 32'd100_000_000,
  parameter logic [19:0] WAIT_FARE       = 20'd1,
  parameter logic [19:0] MAX_VAL         = 20'd999
) (
  input logic        sys_clk,
  input logic        sys_rst_n,
  taxi_fare_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t      state;
  logic [2:0]  enc_sync;
  logic        enc_rise;
  logic [15:0] sub_cnt;
  logic [31:0] wait_cnt;
  logic [19:0] dist_q;
  logic [19:0] price_q;
  logic        upd_q;

  logic        launch_only;
  logic        step_only;
  logic        unit_step;
  logic        wait_hit;
  logic        rate_hit;
  logic [20:0] dist_sum;
  logic [19:0] dist_inc;
  logic [19:0] dist_next;
  logic [19:0] price_add;
  logic [20:0] price_sum;
  logic [19:0] price_next;
  logic        changed;

  // [0],[1] resolve metastability; [2] holds the previous level
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      enc_sync <= '0;
    end else begin
      enc_sync <= {enc_sync[1:0], bus.encoder_pulses};
    end
  end

  assign enc_rise = enc_sync[1] & ~enc_sync[2];

  assign launch_only = bus.flag_key_launch & ~bus.flag_key_step;
  assign step_only   = bus.flag_key_step & ~bus.flag_key_launch;

  assign unit_step =
    enc_rise && (sub_cnt == PULSES_PER_UNIT - 16'd1);
  assign wait_hit =
    !enc_rise && (wait_cnt == WAIT_CYCLES - 32'd1);

  assign dist_sum = {1'b0, dist_q} + 21'd1;
  assign dist_inc = (dist_sum > {1'b0, MAX_VAL})
                  ? MAX_VAL : dist_sum[19:0];
  assign dist_next = unit_step ? dist_inc : dist_q;

  // A clamped distance that did not move earns no rate charge
  assign rate_hit = unit_step
                 && (dist_inc != dist_q)
                 && (dist_inc > BASE_DIST);

  always_comb begin
    price_add = '0;
    unique case (1'b1)
      rate_hit: price_add = RATE_PER_UNIT;
      wait_hit: price_add = WAIT_FARE;
      default:  price_add = '0;
    endcase
  end

  assign price_sum  = {1'b0, price_q} + {1'b0, price_add};
  assign price_next = (price_sum > {1'b0, MAX_VAL})
                    ? MAX_VAL : price_sum[19:0];

  assign changed = (dist_next != dist_q)
                || (price_next != price_q);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      sub_cnt  <= '0;
      wait_cnt <= '0;
      dist_q   <= '0;
      price_q  <= '0;
      upd_q    <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (launch_only) begin
            state    <= RUN;
            dist_q   <= '0;
            price_q  <= BASE_FARE;
            sub_cnt  <= '0;
            wait_cnt <= '0;
            upd_q    <= 1'b1;
          end
        end
        RUN: begin
          if (step_only) begin
            state    <= PAUSE;
            wait_cnt <= '0;
          end else begin
            if (enc_rise) begin
              sub_cnt  <= unit_step ? 16'd0
                                    : sub_cnt + 16'd1;
              wait_cnt <= '0;
            end else if (wait_hit) begin
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + 32'd1;
            end
            dist_q  <= dist_next;
            price_q <= price_next;
            upd_q   <= changed;
          end
        end
        PAUSE: begin
          if (launch_only) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (step_only) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.distance   = dist_q;
  assign bus.price      = price_q;
  assign bus.trip_state = state;
  assign bus.update     = upd_q;

endmodule

// File: tb/tb_taxi_fare_engine.sv
// Scoreboarded random and directed bench for taxi_fare_engine
// against a trip-level fare model.
module tb_taxi_fare_engine;

  localparam int PPU  = 4;
  localparam int BD   = 3;
  localparam int BF   = 8;
  localparam int RATE = 2;
  localparam int WC   = 20;
  localparam int WF   = 1;
  localparam int MAXV = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  taxi_fare_if bus();

  taxi_fare_engine #(
    .PULSES_PER_UNIT(16'd4),
    .BASE_DIST      (20'd3),
    .BASE_FARE      (20'd8),
    .RATE_PER_UNIT  (20'd2),
    .WAIT_CYCLES    (32'd20),
    .WAIT_FARE      (20'd1),
    .MAX_VAL        (20'd15)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (bus)
  );

  typedef struct packed {
    logic [19:0] d;
    logic [19:0] p;
    logic [1:0]  s;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // trip-level model: fare derived from totals, not from counters
  int m_state = 0;
  bit m_trip  = 0;
  int m_pulses, m_waits, m_quiet;
  int m_dist  = 0;
  int m_price = 0;
  bit r1, r2, enc_prev;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.update === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_update d=%0d p=%0d",
                 bus.distance, bus.price);
      end else begin
        e = exp_q.pop_front();
        if (bus.distance !== e.d || bus.price !== e.p
            || bus.trip_state !== e.s) begin
          errors++;
          $display("FAIL update_values got d=%0d p=%0d s=%0d exp d=%0d p=%0d s=%0d",
                   bus.distance, bus.price, bus.trip_state,
                   e.d, e.p, e.s);
        end
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_trip = 0;
    m_pulses = 0; m_waits = 0; m_quiet = 0;
    m_dist = 0; m_price = 0;
    r1 = 0; r2 = 0; enc_prev = 0;
  endtask

  // drive one cycle of inputs, predict the next edge, advance
  task automatic tick(input bit l, input bit s, input bit e);
    bit ev, launched;
    int od, op, units, cd, extra, fare;
    bus.flag_key_launch = l;
    bus.flag_key_step   = s;
    bus.encoder_pulses  = e;
    ev = r2; r2 = r1; r1 = e && !enc_prev; enc_prev = e;
    od = m_dist; op = m_price; launched = 0;
    case (m_state)
      0: if (l && !s) begin
        m_state = 1; m_trip = 1; launched = 1;
        m_pulses = 0; m_waits = 0; m_quiet = 0;
      end
      1: if (s && !l) begin
        m_state = 2;
      end else if (ev) begin
        m_pulses++; m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet == WC) begin
          m_waits++; m_quiet = 0;
        end
      end
      default: if (l && !s) begin
        m_state = 1; m_quiet = 0;
      end else if (s && !l) begin
        m_state = 0;
      end
    endcase
    if (m_trip) begin
      units = m_pulses / PPU;
      cd    = (units > MAXV) ? MAXV : units;
      extra = (cd > BD) ? cd - BD : 0;
      fare  = BF + RATE * extra + WF * m_waits;
      m_dist  = cd;
      m_price = (fare > MAXV) ? MAXV : fare;
    end
    if (launched || m_dist != od || m_price != op)
      exp_q.push_back({m_dist[19:0], m_price[19:0], m_state[1:0]});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      tick(0, 0, 1);
      tick(0, 0, 0);
      tick(0, 0, 0);
    end
  endtask

  task automatic chk_outs(input string tag, input int d,
                          input int p, input int s);
    chk({tag, "_dist"},  bus.distance,   d);
    chk({tag, "_price"}, bus.price,      p);
    chk({tag, "_state"}, bus.trip_state, s);
  endtask

  initial begin
    bus.encoder_pulses  = 1'b0;
    bus.flag_key_launch = 1'b0;
    bus.flag_key_step   = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk_outs("reset", 0, 0, 0);
    chk("reset_update", bus.update, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    tick(1, 0, 0);
    chk_outs("launch", 0, 8, 1);

    pulses(20);
    idle(3);
    chk_outs("run20", 5, 12, 1);

    idle(45);
    chk_outs("wait", 5, 14, 1);

    tick(0, 1, 0);
    chk("pause_state", bus.trip_state, 2);
    pulses(8);
    idle(2);
    chk_outs("paused", 5, 14, 2);
    tick(1, 0, 0);
    chk_outs("resume", 5, 14, 1);
    tick(0, 1, 0);
    tick(0, 1, 0);
    chk_outs("idle_hold", 5, 14, 0);
    tick(1, 0, 0);
    chk_outs("relaunch", 0, 8, 1);

    pulses(40);
    idle(3);
    chk_outs("sat", 10, 15, 1);
    idle(25);
    chk_outs("sat_wait", 10, 15, 1);

    tick(0, 1, 0);
    tick(0, 1, 0);
    tick(1, 1, 0);
    chk("both_flags", bus.trip_state, 0);

    tick(1, 0, 0);
    pulses(8);
    idle(3);
    chk_outs("prereset", 2, 8, 1);
    @(negedge clk);
    chk("drain_before_reset", exp_q.size(), 0);
    #2 rst_n = 1'b0;
    #1;
    chk_outs("async_reset", 0, 0, 0);
    chk("async_reset_update", bus.update, 0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    begin
      bit enc;
      enc = 0;
      for (int i = 0; i < 4000; i++) begin
        bit l, s;
        l = ($urandom_range(0, 59) == 0);
        s = ($urandom_range(0, 79) == 0);
        if (i < 1500 && $urandom_range(0, 1) == 0) enc = ~enc;
        else if (i >= 1500 && $urandom_range(0, 29) == 0) enc = ~enc;
        tick(l, s, enc);
      end
    end
    idle(5);
    chk_outs("random_end", m_dist, m_price, m_state);
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
